// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD bus controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    // Clear and both home encodings (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(lcd_entry_t e);
        return !e.rs && (e.data == LCD_CMD_CLEAR || e.data == LCD_CMD_HOME ||
                         e.data == (LCD_CMD_HOME | 8'h01));
    endfunction

    function automatic int max_int(int a, int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// lcd_fifo: synchronous FIFO of LCD write entries, head visible combinationally.
module lcd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic                     pop,
    input  lcd_entry_t               din,
    output lcd_entry_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    lcd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: queues LSU LCD writes and replays them on an HD44780-style bus with programmable timing.
module lcd_bus_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_POWERUP   = 100,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 4,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 10,
    parameter int T_EXEC_LONG = 40
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wr_vld,
    input  logic                          i_wr_rs,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_wr_rdy,
    input  logic                          i_lcd_on_set,
    input  logic                          i_lcd_on,
    output logic                          o_lcd_on,
    output logic                          o_lcd_en,
    output logic                          o_lcd_rs,
    output logic                          o_lcd_rw,
    output logic [7:0]                    o_lcd_data,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int T_MAX = max_int(max_int(max_int(T_POWERUP, T_SETUP), max_int(T_EN_HIGH, T_HOLD)),
                                   max_int(T_EXEC, T_EXEC_LONG));
    localparam int CW = $clog2(T_MAX) + 1;

    lcd_state_e    state;
    lcd_state_e    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lim;
    logic          done;
    logic          pop;
    logic          full;
    logic          empty;
    lcd_entry_t    wr_entry;
    lcd_entry_t    head;
    lcd_entry_t    bus;

    assign wr_entry = '{rs: i_wr_rs, data: i_wr_data};

    lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (i_wr_vld),
        .pop     (pop),
        .din     (wr_entry),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (o_fifo_level)
    );

    assign o_wr_rdy   = !full;
    assign o_lcd_rs   = bus.rs;
    assign o_lcd_data = bus.data;
    assign o_lcd_rw   = 1'b0;
    assign o_busy     = !(state == ST_IDLE && empty);

    // The counter runs up from 0 on state entry; lim is the last cycle of the current state.
    always_comb begin
        lim = state == ST_PWRUP ? CW'(T_POWERUP - 1) :
              state == ST_SETUP ? CW'(T_SETUP - 1) :
              state == ST_EN_HI ? CW'(T_EN_HIGH - 1) :
              state == ST_HOLD  ? CW'(T_HOLD - 1) :
              is_long_cmd(bus)  ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
        done    = cnt == lim;
        pop     = state == ST_IDLE && !empty;
        state_n = state;
        case (state)
            ST_PWRUP: if (done) state_n = ST_IDLE;
            ST_IDLE:  if (!empty) state_n = ST_SETUP;
            ST_SETUP: if (done) state_n = ST_EN_HI;
            ST_EN_HI: if (done) state_n = ST_HOLD;
            ST_HOLD:  if (done) state_n = ST_WAIT;
            ST_WAIT:  if (done) state_n = ST_IDLE;
            default:  state_n = ST_PWRUP;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_PWRUP;
            cnt      <= '0;
            bus      <= '0;
            o_lcd_en <= 1'b0;
            o_lcd_on <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= (state_n != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
            o_lcd_en <= state_n == ST_EN_HI;
            if (pop) bus <= head;
            if (i_lcd_on_set) o_lcd_on <= i_lcd_on;
        end
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb_lcd_bus_ctrl: directed vector bench for lcd_bus_ctrl with a short power-up time.
module tb_lcd_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_vld;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_rdy;
    logic       on_set;
    logic       on_val;
    logic       lcd_on;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       busy;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_bus_ctrl #(.FIFO_DEPTH(4), .T_POWERUP(5)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wr_vld     (wr_vld),
        .i_wr_rs      (wr_rs),
        .i_wr_data    (wr_data),
        .o_wr_rdy     (wr_rdy),
        .i_lcd_on_set (on_set),
        .i_lcd_on     (on_val),
        .o_lcd_on     (lcd_on),
        .o_lcd_en     (lcd_en),
        .o_lcd_rs     (lcd_rs),
        .o_lcd_rw     (lcd_rw),
        .o_lcd_data   (lcd_data),
        .o_busy       (busy),
        .o_fifo_level (level)
    );

    typedef struct {
        logic       vld;
        logic       rs;
        logic [7:0] data;
        logic       exp_rdy;
        logic [2:0] exp_level;
        logic       exp_busy;
    } burst_vec_t;

    typedef struct {
        logic       rs1;
        logic [7:0] d1;
        logic       rs2;
        logic [7:0] d2;
        int         pop2;
        int         rise2;
    } pair_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 100 && busy; k++) tick;
        chk(name, busy, 0);
    endtask

    // Two back-to-back writes; edges are counted from the accept edge of the first (k=0).
    task automatic run_pair(input pair_vec_t v, input bit do_on, input int idx);
        int   rise1, fall1, pop2, rise2, bad;
        logic prev;
        wr_vld = 1'b1; wr_rs = v.rs1; wr_data = v.d1;
        tick;
        chk($sformatf("pair%0d_level_after_push", idx), level, 1);
        wr_rs = v.rs2; wr_data = v.d2;
        tick;
        wr_vld = 1'b0;
        chk($sformatf("pair%0d_level_push_pop", idx), level, 1);
        rise1 = -1; fall1 = -1; pop2 = -1; rise2 = -1;
        bad  = (lcd_rs !== v.rs1 || lcd_data !== v.d1) ? 1 : 0;
        prev = lcd_en;
        for (int k = 2; k <= 110 && rise2 < 0; k++) begin
            if (do_on && k == 5) begin on_set = 1'b1; on_val = 1'b1; end
            tick;
            if (do_on && k == 5) begin
                on_set = 1'b0;
                chk("lcd_on_next_cycle", lcd_on, 1);
            end
            if (lcd_en && !prev) begin
                if (rise1 < 0) rise1 = k;
                else begin
                    rise2 = k;
                    chk($sformatf("pair%0d_rs2", idx), lcd_rs, v.rs2);
                    chk($sformatf("pair%0d_data2", idx), lcd_data, v.d2);
                end
            end
            if (!lcd_en && prev && fall1 < 0) fall1 = k;
            if (level == 0 && pop2 < 0) pop2 = k;
            if (pop2 < 0 && (lcd_rs !== v.rs1 || lcd_data !== v.d1)) bad++;
            if (lcd_rw !== 1'b0) bad++;
            prev = lcd_en;
        end
        chk($sformatf("pair%0d_en_rise1", idx), rise1, 3);
        chk($sformatf("pair%0d_en_fall1", idx), fall1, 7);
        chk($sformatf("pair%0d_pop2", idx), pop2, v.pop2);
        chk($sformatf("pair%0d_en_rise2", idx), rise2, v.rise2);
        chk($sformatf("pair%0d_bus_unstable_cycles", idx), bad, 0);
        wait_idle($sformatf("pair%0d_idle", idx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        burst_vec_t burst [6];
        pair_vec_t  pairs [6];
        logic [7:0] seen [4];
        int         nrise, enbad;
        logic       prev;

        burst[0] = '{1'b1, 1'b1, 8'h30, 1'b1, 3'd1, 1'b1};
        burst[1] = '{1'b1, 1'b1, 8'h31, 1'b1, 3'd2, 1'b1};
        burst[2] = '{1'b1, 1'b1, 8'h32, 1'b1, 3'd3, 1'b1};
        burst[3] = '{1'b1, 1'b1, 8'h33, 1'b1, 3'd4, 1'b1};
        burst[4] = '{1'b1, 1'b1, 8'h34, 1'b0, 3'd4, 1'b1};
        burst[5] = '{1'b1, 1'b1, 8'h35, 1'b0, 3'd3, 1'b1};

        pairs[0] = '{1'b1, 8'h41, 1'b1, 8'h55, 20, 22};
        pairs[1] = '{1'b0, 8'h01, 1'b1, 8'h42, 50, 52};
        pairs[2] = '{1'b0, 8'h03, 1'b1, 8'h43, 50, 52};
        pairs[3] = '{1'b1, 8'h01, 1'b1, 8'h44, 20, 22};
        pairs[4] = '{1'b0, 8'h02, 1'b0, 8'h04, 50, 52};
        pairs[5] = '{1'b0, 8'h04, 1'b1, 8'h45, 20, 22};

        rst = 1'b1; wr_vld = 1'b0; wr_rs = 1'b0; wr_data = 8'h00; on_set = 1'b0; on_val = 1'b0;
        tick;
        tick;
        chk("reset_en", lcd_en, 0);
        chk("reset_rs", lcd_rs, 0);
        chk("reset_data", lcd_data, 0);
        chk("reset_on", lcd_on, 0);
        chk("reset_rw", lcd_rw, 0);
        chk("reset_rdy", wr_rdy, 1);
        chk("reset_busy", busy, 1);
        chk("reset_level", level, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pwrup_busy_%0d", i), busy, 1);
            chk($sformatf("pwrup_en_%0d", i), lcd_en, 0);
            tick;
        end
        chk("idle_busy", busy, 0);
        chk("idle_rdy", wr_rdy, 1);
        chk("idle_level", level, 0);
        chk("idle_en", lcd_en, 0);
        tick;

        for (int p = 0; p < 6; p++) run_pair(pairs[p], p == 0, p);

        // Burst of six issued right at reset release, while still powering up.
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_vld = burst[i].vld; wr_rs = burst[i].rs; wr_data = burst[i].data;
            chk($sformatf("burst%0d_rdy", i), wr_rdy, burst[i].exp_rdy);
            tick;
            chk($sformatf("burst%0d_level", i), level, burst[i].exp_level);
            chk($sformatf("burst%0d_busy", i), busy, burst[i].exp_busy);
        end
        wr_vld = 1'b0;
        nrise = 0;
        prev  = lcd_en;
        for (int k = 0; k < 150; k++) begin
            tick;
            if (lcd_en && !prev) begin
                if (nrise < 4) seen[nrise] = lcd_data;
                nrise++;
            end
            prev = lcd_en;
        end
        chk("burst_pulses", nrise, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("burst_order_%0d", i), seen[i], 8'h30 + 8'(i));
        chk("burst_idle", busy, 0);

        // Reset while EN is high with two entries still queued.
        wr_vld = 1'b1; wr_rs = 1'b1; wr_data = 8'h50;
        tick;
        wr_data = 8'h51;
        tick;
        wr_data = 8'h52;
        tick;
        wr_vld = 1'b0;
        tick;
        chk("midreset_en_before", lcd_en, 1);
        chk("midreset_level_before", level, 2);
        rst = 1'b1;
        #1;
        chk("midreset_en", lcd_en, 0);
        chk("midreset_level", level, 0);
        chk("midreset_busy", busy, 1);
        chk("midreset_rdy", wr_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("replay_busy_%0d", i), busy, 1);
            tick;
        end
        chk("replay_idle", busy, 0);
        enbad = 0;
        for (int k = 0; k < 40; k++) begin
            if (lcd_en !== 1'b0 || level !== 3'd0) enbad++;
            tick;
        end
        chk("replay_no_stale_pulse", enbad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
